contador_bcd_modulo: RTL and testbench
======================================

# contador_bcd_modulo

Parametrised two-digit BCD modulo counter, the successor to the fixed minutes counter in the RelojDigital clock. One instance serves seconds (MODULO 60), minutes (MODULO 60) or hours (MODULO 24 or 12) by parameter. It adds up/down counting, parallel load, a registered wrap pulse and a terminal-count flag for synchronous cascading. Stages chain by driving the next stage's `habilitar` from this stage's `habilitar & terminal`.

## Interface
- `MODULO`, default 60: count range 0..MODULO-1; legal 2..99.
- `DEC_W`, default 3: width of the tens digit; must hold (MODULO-1)/10.
- `INICIO`, default 0: value loaded on reset, binary; must be < MODULO.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `habilitar`  in  1  count tick: one step per cycle while high.
- `ajuste`  in  1  manual adjust: one step per cycle while high, never wraps out.
- `bajar`  in  1  direction: 0 counts up, 1 counts down; applies to `habilitar` and `ajuste`.
- `cargar`  in  1  parallel load strobe.
- `val_dec`  in  DEC_W  tens digit to load.
- `val_uni`  in  4  units digit to load.
- `decenas`  out  DEC_W  tens digit, registered.
- `unidades`  out  4  units digit, registered BCD 0..9.
- `acarreo`  out  1  registered one-cycle wrap pulse.
- `terminal`  out  1  combinational: up ? (value == MODULO-1) : (value == 0).
- `invalido`  out  1  registered one-cycle pulse on a rejected load.

## Operation
- Value V = 10*decenas + unidades. V is always in 0..MODULO-1, and unidades is always 0..9.
- Per-edge priority: `reset` > `cargar` > `habilitar` > `ajuste` > hold.
- reset: V = INICIO; acarreo = 0; invalido = 0.
- cargar: the load is valid if val_uni ≤ 9 and 10*val_dec+val_uni < MODULO.
  - Valid: V takes the loaded value.
  - Invalid: V holds and invalido = 1 for one cycle.
  - In both cases acarreo = 0, and habilitar and ajuste are ignored that cycle.
- habilitar, counting up:
  - unidades 9 → 0 with decenas+1.
  - V = MODULO-1 → 0 with acarreo = 1. This covers digit combinations such as 23 → 00 and 59 → 00.
- habilitar, counting down:
  - unidades 0 → 9 with decenas-1.
  - V = 0 → MODULO-1 with acarreo = 1.
- ajuste: same step and wrap as habilitar, but acarreo stays 0. Manual setting never propagates to the next stage.
- habilitar and ajuste high together: exactly one step, treated as habilitar (acarreo allowed).
- Otherwise V holds; acarreo = 0 and invalido = 0 every cycle in which their condition is absent.
- bajar may change on any cycle; it takes effect on the step it is sampled with.
- terminal depends only on the current V and bajar; it is independent of habilitar.

## Timing
- Latency 1 cycle: inputs are sampled at edge N; decenas, unidades, acarreo and invalido reflect them after edge N.
- acarreo is high in exactly the cycle V first shows the wrapped value (0 up, MODULO-1 down).
- Continuous habilitar gives a period of MODULO cycles and one acarreo per period.
- Cascade: next.habilitar = habilitar & terminal. It is combinational, so all stages update on the same edge with no ripple delay.
- reset asserted mid-count takes effect at the next edge and overrides a simultaneous cargar or habilitar.
- Reset values: decenas/unidades = INICIO digits, acarreo = 0, invalido = 0. terminal follows from the reset V.

## Test plan
- MODULO=60, INICIO=0: reset, then hold habilitar for 61 cycles → V steps 00..59, then 00; acarreo high only on the 60th cycle; V=01 at cycle 61; unidades never exceeds 9.
- MODULO=24: load 23, pulse habilitar → V=00 and acarreo=1. Then bajar=1 and pulse habilitar → V=23 and acarreo=1.
- MODULO=60: V=59, pulse ajuste (up) → V=00 and acarreo=0. Next, habilitar and ajuste together at V=59 → V=00, acarreo=1, and only a single step taken.
- MODULO=60: cargar with 6/0 → invalido=1 and V unchanged. Cargar with 4/10 → invalido=1. Cargar with 4/5 → V=45 and invalido=0. Cargar with habilitar also high → V equals the loaded value, with no increment.
- Two-stage cascade (60 × 24), tick every cycle from 23:59 → next edge shows 00:00. The units stage asserts acarreo; the hours stage wraps with acarreo in the same cycle.
- Assert reset at V=37 with habilitar=1 → V=INICIO after one edge, acarreo=0. Then check reset with INICIO=12 → V=12.

Source files
------------

// File: rtl/contador_bcd_modulo.sv
// Two-digit BCD modulo counter with up/down stepping, parallel load, registered
// wrap pulse and combinational terminal-count flag for synchronous cascading.
module contador_bcd_modulo #(
  parameter int unsigned MODULO = 60,
  parameter int unsigned DEC_W  = 3,
  parameter int unsigned INICIO = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             habilitar,
  input  logic             ajuste,
  input  logic             bajar,
  input  logic             cargar,
  input  logic [DEC_W-1:0] val_dec,
  input  logic [3:0]       val_uni,
  output logic [DEC_W-1:0] decenas,
  output logic [3:0]       unidades,
  output logic             acarreo,
  output logic             terminal,
  output logic             invalido
);

  localparam logic [DEC_W-1:0] MAX_DEC = DEC_W'((MODULO - 1) / 10);
  localparam logic [3:0]       MAX_UNI = 4'((MODULO - 1) % 10);
  localparam logic [DEC_W-1:0] INI_DEC = DEC_W'(INICIO / 10);
  localparam logic [3:0]       INI_UNI = 4'(INICIO % 10);

  logic [DEC_W-1:0] dec_q, dec_d;
  logic [3:0]       uni_q, uni_d;
  logic             aca_q, aca_d;
  logic             inv_q, inv_d;
  logic             en_max, en_cero, carga_ok;
  logic [31:0]      carga_val;

  always_comb begin
    en_max    = (dec_q == MAX_DEC) && (uni_q == MAX_UNI);
    en_cero   = (dec_q == '0) && (uni_q == '0);
    carga_val = 32'(val_dec) * 32'd10 + 32'(val_uni);
    carga_ok  = (val_uni <= 4'd9) && (carga_val < MODULO);

    dec_d = dec_q;
    uni_d = uni_q;
    aca_d = 1'b0;
    inv_d = 1'b0;

    if (cargar) begin
      if (carga_ok) begin
        dec_d = val_dec;
        uni_d = val_uni;
      end else begin
        inv_d = 1'b1;
      end
    end else if (habilitar || ajuste) begin
      // Both strobes together still take one step; only habilitar may carry out.
      aca_d = habilitar && (bajar ? en_cero : en_max);
      if (!bajar) begin
        if (en_max) begin
          dec_d = '0;
          uni_d = '0;
        end else if (uni_q == 4'd9) begin
          dec_d = dec_q + DEC_W'(1);
          uni_d = '0;
        end else begin
          uni_d = uni_q + 4'd1;
        end
      end else begin
        if (en_cero) begin
          dec_d = MAX_DEC;
          uni_d = MAX_UNI;
        end else if (uni_q == '0) begin
          dec_d = dec_q - DEC_W'(1);
          uni_d = 4'd9;
        end else begin
          uni_d = uni_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dec_q <= INI_DEC;
      uni_q <= INI_UNI;
      aca_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      dec_q <= dec_d;
      uni_q <= uni_d;
      aca_q <= aca_d;
      inv_q <= inv_d;
    end
  end

  assign decenas  = dec_q;
  assign unidades = uni_q;
  assign acarreo  = aca_q;
  assign invalido = inv_q;
  assign terminal = bajar ? en_cero : en_max;

endmodule

// File: tb/tb_contador_bcd_modulo.sv
// Scoreboard bench for contador_bcd_modulo: a 60 stage, a 24 stage (standalone
// or cascaded behind the 60 stage) and a 60 stage with INICIO=12.
module tb_contador_bcd_modulo;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      nm;
    logic [9:0] val;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_h[$];
  exp_t sb_i[$];
  int total = 0;
  int bad   = 0;

  // minutes-style stage, MODULO 60
  logic       a_rst = 1'b0, a_hab = 1'b0, a_aju = 1'b0, a_baj = 1'b0, a_car = 1'b0;
  logic [2:0] a_vd = '0;
  logic [3:0] a_vu = '0;
  logic [2:0] a_dec;
  logic [3:0] a_uni;
  logic       a_aca, a_term, a_inv;

  // hours stage, MODULO 24
  logic       h_rst = 1'b0, h_hab = 1'b0, h_aju = 1'b0, h_baj = 1'b0, h_car = 1'b0;
  logic [1:0] h_vd = '0;
  logic [3:0] h_vu = '0;
  logic [1:0] h_dec;
  logic [3:0] h_uni;
  logic       h_aca, h_term, h_inv;
  logic       casc = 1'b0;
  logic       h_hab_in;

  // MODULO 60, INICIO 12
  logic       i_rst = 1'b0, i_hab = 1'b0, i_aju = 1'b0, i_baj = 1'b0, i_car = 1'b0;
  logic [2:0] i_vd = '0;
  logic [3:0] i_vu = '0;
  logic [2:0] i_dec;
  logic [3:0] i_uni;
  logic       i_aca, i_term, i_inv;

  assign h_hab_in = casc ? (a_hab & a_term) : h_hab;

  logic [9:0] obs_a, obs_h, obs_i;
  assign obs_a = {1'b0, a_dec, a_uni, a_aca, a_inv};
  assign obs_h = {2'b00, h_dec, h_uni, h_aca, h_inv};
  assign obs_i = {1'b0, i_dec, i_uni, i_aca, i_inv};

  contador_bcd_modulo #(.MODULO(60), .DEC_W(3), .INICIO(0)) u_a (
    .clock(clock), .reset(a_rst), .habilitar(a_hab), .ajuste(a_aju), .bajar(a_baj),
    .cargar(a_car), .val_dec(a_vd), .val_uni(a_vu), .decenas(a_dec), .unidades(a_uni),
    .acarreo(a_aca), .terminal(a_term), .invalido(a_inv));

  contador_bcd_modulo #(.MODULO(24), .DEC_W(2), .INICIO(0)) u_h (
    .clock(clock), .reset(h_rst), .habilitar(h_hab_in), .ajuste(h_aju), .bajar(h_baj),
    .cargar(h_car), .val_dec(h_vd), .val_uni(h_vu), .decenas(h_dec), .unidades(h_uni),
    .acarreo(h_aca), .terminal(h_term), .invalido(h_inv));

  contador_bcd_modulo #(.MODULO(60), .DEC_W(3), .INICIO(12)) u_i (
    .clock(clock), .reset(i_rst), .habilitar(i_hab), .ajuste(i_aju), .bajar(i_baj),
    .cargar(i_car), .val_dec(i_vd), .val_uni(i_vu), .decenas(i_dec), .unidades(i_uni),
    .acarreo(i_aca), .terminal(i_term), .invalido(i_inv));

  function automatic logic [9:0] pk(int v, bit aca, bit inv);
    return {4'(v / 10), 4'(v % 10), aca, inv};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    a_rst = 1'b1; a_hab = 1'b1; h_rst = 1'b1; i_rst = 1'b1;
    sb_a.push_back('{"reset_a", pk(0, 0, 0)});
    sb_h.push_back('{"reset_h", pk(0, 0, 0)});
    sb_i.push_back('{"reset_inicio12", pk(12, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    e = sb_h.pop_front(); total++;
    if (obs_h !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_h, e.val); end
    e = sb_i.pop_front(); total++;
    if (obs_i !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_i, e.val); end
    total++;
    if (a_term !== 1'b0) begin bad++; $display("FAIL reset_term: got %b want 0", a_term); end
    a_rst = 1'b0; a_hab = 1'b0; h_rst = 1'b0; i_rst = 1'b0;
  endtask

  task automatic test_count_up();
    exp_t e;
    bit   t_exp;
    for (int k = 1; k <= 61; k++) begin
      a_hab = 1'b1;
      sb_a.push_back('{$sformatf("count_%0d", k), pk(k % 60, k == 60, 0)});
      tick();
      e = sb_a.pop_front(); total++;
      if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
      t_exp = ((k % 60) == 59);
      total++;
      if (a_term !== t_exp) begin bad++; $display("FAIL term_%0d: got %b want %b", k, a_term, t_exp); end
    end
    a_hab = 1'b0;
  endtask

  task automatic test_wrap_24();
    exp_t e;
    h_car = 1'b1; h_vd = 2'd2; h_vu = 4'd3;
    sb_h.push_back('{"h_load23", pk(23, 0, 0)});
    tick();
    e = sb_h.pop_front(); total++;
    if (obs_h !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_h, e.val); end
    h_car = 1'b0; h_hab = 1'b1;
    sb_h.push_back('{"h_wrap_up", pk(0, 1, 0)});
    tick();
    e = sb_h.pop_front(); total++;
    if (obs_h !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_h, e.val); end
    h_baj = 1'b1;
    sb_h.push_back('{"h_wrap_down", pk(23, 1, 0)});
    tick();
    e = sb_h.pop_front(); total++;
    if (obs_h !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_h, e.val); end
    h_hab = 1'b0;
    sb_h.push_back('{"h_hold", pk(23, 0, 0)});
    tick();
    e = sb_h.pop_front(); total++;
    if (obs_h !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_h, e.val); end
    total++;
    if (h_term !== 1'b0) begin bad++; $display("FAIL h_term_down23: got %b want 0", h_term); end
    h_baj = 1'b0;
    #1;
    total++;
    if (h_term !== 1'b1) begin bad++; $display("FAIL h_term_up23: got %b want 1", h_term); end
  endtask

  task automatic test_ajuste();
    exp_t e;
    a_car = 1'b1; a_vd = 3'd5; a_vu = 4'd9;
    sb_a.push_back('{"aju_load59", pk(59, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    a_car = 1'b0; a_aju = 1'b1;
    sb_a.push_back('{"aju_up_wrap", pk(0, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    a_aju = 1'b0; a_car = 1'b1;
    sb_a.push_back('{"aju_reload59", pk(59, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    a_car = 1'b0; a_hab = 1'b1; a_aju = 1'b1;
    sb_a.push_back('{"hab_aju_wrap", pk(0, 1, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    a_hab = 1'b0; a_aju = 1'b0;
    sb_a.push_back('{"single_step", pk(0, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    a_baj = 1'b1;
    #1;
    total++;
    if (a_term !== 1'b1) begin bad++; $display("FAIL term_down_zero: got %b want 1", a_term); end
    a_aju = 1'b1;
    sb_a.push_back('{"aju_down_wrap", pk(59, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    a_aju = 1'b0; a_baj = 1'b0;
  endtask

  task automatic test_load();
    exp_t e;
    a_car = 1'b1; a_vd = 3'd6; a_vu = 4'd0;
    sb_a.push_back('{"load_6_0", pk(59, 0, 1)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    a_vd = 3'd4; a_vu = 4'd10;
    sb_a.push_back('{"load_4_10", pk(59, 0, 1)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    a_vu = 4'd5;
    sb_a.push_back('{"load_4_5", pk(45, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    a_vd = 3'd3; a_vu = 4'd0; a_hab = 1'b1;
    sb_a.push_back('{"load_with_hab", pk(30, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    a_car = 1'b0; a_hab = 1'b0;
    sb_a.push_back('{"idle_hold", pk(30, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
  endtask

  task automatic test_cascade();
    exp_t e;
    casc = 1'b1;
    a_car = 1'b1; a_vd = 3'd5; a_vu = 4'd9;
    h_car = 1'b1; h_vd = 2'd2; h_vu = 4'd3;
    sb_a.push_back('{"casc_load_a", pk(59, 0, 0)});
    sb_h.push_back('{"casc_load_h", pk(23, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    e = sb_h.pop_front(); total++;
    if (obs_h !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_h, e.val); end
    a_car = 1'b0; h_car = 1'b0; a_hab = 1'b1;
    #1;
    total++;
    if (h_hab_in !== 1'b1) begin bad++; $display("FAIL casc_enable: got %b want 1", h_hab_in); end
    sb_a.push_back('{"casc_wrap_a", pk(0, 1, 0)});
    sb_h.push_back('{"casc_wrap_h", pk(0, 1, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    e = sb_h.pop_front(); total++;
    if (obs_h !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_h, e.val); end
    sb_a.push_back('{"casc_next_a", pk(1, 0, 0)});
    sb_h.push_back('{"casc_next_h", pk(0, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    e = sb_h.pop_front(); total++;
    if (obs_h !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_h, e.val); end
    a_hab = 1'b0; casc = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    a_car = 1'b1; a_vd = 3'd3; a_vu = 4'd7;
    i_car = 1'b1; i_vd = 3'd3; i_vu = 4'd7;
    sb_a.push_back('{"b2b_load_a", pk(37, 0, 0)});
    sb_i.push_back('{"b2b_load_i", pk(37, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    e = sb_i.pop_front(); total++;
    if (obs_i !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_i, e.val); end
    a_vd = 3'd1; a_vu = 4'd1; a_hab = 1'b1; a_rst = 1'b1;
    i_car = 1'b0; i_hab = 1'b1; i_rst = 1'b1;
    sb_a.push_back('{"rst_over_load", pk(0, 0, 0)});
    sb_i.push_back('{"rst_inicio12", pk(12, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    e = sb_i.pop_front(); total++;
    if (obs_i !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_i, e.val); end
    a_rst = 1'b0; a_car = 1'b0; i_rst = 1'b0;
    sb_a.push_back('{"after_rst_a", pk(1, 0, 0)});
    sb_i.push_back('{"after_rst_i", pk(13, 0, 0)});
    tick();
    e = sb_a.pop_front(); total++;
    if (obs_a !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_a, e.val); end
    e = sb_i.pop_front(); total++;
    if (obs_i !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs_i, e.val); end
    a_hab = 1'b0; i_hab = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_count_up();
    test_wrap_24();
    test_ajuste();
    test_load();
    test_cascade();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
